// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
//   Program counter and instruction-fetch stage in front of the jump/decode
//   stage. It holds the PC, drives a synchronous instruction ROM with a
//   1-cycle read latency, presents the fetched instruction, and applies
//   redirects coming back from jump control. It also supplies the interrupt
//   return address.
//
// Ports
//   i_clk             clock, all state on the rising edge
//   i_reset           asynchronous, active-high reset
//   i_stall           hold the fetch stage (downstream not ready)
//   i_pc_mux_sel      redirect request from jump control
//   i_jmp_loc         redirect target
//   o_imem_addr       ROM address (the current PC)
//   o_imem_en         ROM read enable; the ROM holds its output while low
//   i_imem_data       ROM data, valid the cycle after o_imem_en=1
//   o_ins             fetched instruction, or NOP_INS when nothing is fetched
//   o_ins_valid       o_ins holds a real instruction
//   o_ins_pc          address of o_ins
//   o_current_address interrupt return address:
//                     o_ins_valid ? o_ins_pc+1 : PC (wraps)
// ---------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter int                 ADDR_W   = 8,
  parameter int                 INS_W    = 20,
  parameter logic [ADDR_W-1:0]  RESET_PC = 8'h00,
  parameter logic [INS_W-1:0]   NOP_INS  = 20'h00000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_stall,
  input  logic              i_pc_mux_sel,
  input  logic [ADDR_W-1:0] i_jmp_loc,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic              o_imem_en,
  input  logic [INS_W-1:0]  i_imem_data,
  output logic [INS_W-1:0]  o_ins,
  output logic              o_ins_valid,
  output logic [ADDR_W-1:0] o_ins_pc,
  output logic [ADDR_W-1:0] o_current_address
);

  // BOOT: no fetch yet since reset, redirects are ignored.
  // RUN: streaming sequential fetches.
  // REFILL: PC was just loaded by a redirect, no valid instruction yet.
  typedef enum logic [1:0] {
    S_BOOT   = 2'd0,
    S_RUN    = 2'd1,
    S_REFILL = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] r_ins_pc;
  logic [ADDR_W-1:0] w_ins_pc_nxt;
  logic              r_fetched;
  logic              w_fetched_nxt;
  logic              w_imem_en;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_ins_pc_inc;

  // Natural-width adds wrap modulo 2^ADDR_W.
  assign w_pc_inc     = r_pc + ADDR_ONE;
  assign w_ins_pc_inc = r_ins_pc + ADDR_ONE;

  // Next-state / ROM-enable logic. Redirect beats stall; a plain stall
  // leaves everything held with the ROM disabled so its output stays put.
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_ins_pc_nxt  = r_ins_pc;
    w_fetched_nxt = r_fetched;
    w_imem_en     = 1'b0;
    case (r_state)
      S_BOOT: begin
        if (!i_stall) begin
          w_imem_en     = 1'b1;
          w_ins_pc_nxt  = r_pc;
          w_pc_nxt      = w_pc_inc;
          w_fetched_nxt = 1'b1;
          w_state_nxt   = S_RUN;
        end else begin
          w_imem_en     = 1'b0;
        end
      end
      S_RUN, S_REFILL: begin
        if (i_pc_mux_sel) begin
          // Discard the in-flight slot; target is fetched next cycle.
          w_imem_en     = 1'b0;
          w_pc_nxt      = i_jmp_loc;
          w_fetched_nxt = 1'b0;
          w_state_nxt   = S_REFILL;
        end else if (!i_stall) begin
          w_imem_en     = 1'b1;
          w_ins_pc_nxt  = r_pc;
          w_pc_nxt      = w_pc_inc;
          w_fetched_nxt = 1'b1;
          w_state_nxt   = S_RUN;
        end else begin
          w_imem_en     = 1'b0;
        end
      end
      default: begin
        // Unreachable encoding: recover as if freshly reset.
        w_imem_en     = 1'b0;
        w_pc_nxt      = RESET_PC;
        w_ins_pc_nxt  = {ADDR_W{1'b0}};
        w_fetched_nxt = 1'b0;
        w_state_nxt   = S_BOOT;
      end
    endcase
  end

  // State register with asynchronous reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= S_BOOT;
      r_pc      <= RESET_PC;
      r_ins_pc  <= {ADDR_W{1'b0}};
      r_fetched <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_ins_pc  <= w_ins_pc_nxt;
      r_fetched <= w_fetched_nxt;
    end
  end

  assign o_imem_addr       = r_pc;
  assign o_imem_en         = w_imem_en;
  assign o_ins             = r_fetched ? i_imem_data : NOP_INS;
  assign o_ins_valid       = r_fetched;
  assign o_ins_pc          = r_ins_pc;
  // In REFILL the PC already holds the redirect target, which is the
  // correct resume point for an interrupt taken during the bubble.
  assign o_current_address = r_fetched ? w_ins_pc_inc : r_pc;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios with literal
// expectations, then randomized stall/redirect/reset traffic compared every
// cycle against a behavioural model of the fetch stage.
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        sel;
  logic [7:0]  jmp;
  logic [7:0]  imem_addr;
  logic        imem_en;
  logic [19:0] imem_data;
  logic [19:0] ins;
  logic        ins_valid;
  logic [7:0]  ins_pc;
  logic [7:0]  cur_addr;

  int n_checks = 0;
  int n_errors = 0;

  logic [19:0] rom [256];

  // Behavioural model: what the stage must show after each edge.
  logic [7:0] m_pc;
  logic [7:0] m_ins_pc;
  logic       m_valid;
  logic       m_started;

  pc_fetch_unit dut (
    .i_clk             (clk),
    .i_reset           (rst),
    .i_stall           (stall),
    .i_pc_mux_sel      (sel),
    .i_jmp_loc         (jmp),
    .o_imem_addr       (imem_addr),
    .o_imem_en         (imem_en),
    .i_imem_data       (imem_data),
    .o_ins             (ins),
    .o_ins_valid       (ins_valid),
    .o_ins_pc          (ins_pc),
    .o_current_address (cur_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: 1-cycle latency, output held while enable is low.
  always @(posedge clk) begin
    if (imem_en) imem_data <= rom[imem_addr];
  end

  // Reference model. Redirects count only once a first fetch has happened
  // since reset; a redirect wins over stall; otherwise each unstalled cycle
  // fetches the current PC and advances it.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc      <= 8'h00;
      m_ins_pc  <= 8'h00;
      m_valid   <= 1'b0;
      m_started <= 1'b0;
    end else if (sel && m_started) begin
      m_pc      <= jmp;
      m_valid   <= 1'b0;
    end else if (!stall) begin
      m_ins_pc  <= m_pc;
      m_pc      <= m_pc + 8'd1;
      m_valid   <= 1'b1;
      m_started <= 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [19:0] e_ins;
    logic [7:0]  e_cur;
    logic        e_en;
    e_ins = m_valid ? rom[m_ins_pc] : 20'h00000;
    e_cur = m_valid ? (m_ins_pc + 8'd1) : m_pc;
    e_en  = !(stall || (sel && m_started));
    chk("cmp_ins_valid", {31'd0, ins_valid}, {31'd0, m_valid});
    chk("cmp_imem_addr", {24'd0, imem_addr}, {24'd0, m_pc});
    chk("cmp_imem_en",   {31'd0, imem_en},   {31'd0, e_en});
    chk("cmp_cur_addr",  {24'd0, cur_addr},  {24'd0, e_cur});
    chk("cmp_ins",       {12'd0, ins},       {12'd0, e_ins});
    if (m_valid) chk("cmp_ins_pc", {24'd0, ins_pc}, {24'd0, m_ins_pc});
    else         chk("cmp_ins_pc_rst", {24'd0, ins_pc}, {24'd0, ins_pc & {8{m_started}}});
  endtask

  // Apply inputs just after a falling edge, run one rising edge, then
  // compare at the next falling edge.
  task automatic tick(input logic r, input logic st, input logic sl, input logic [7:0] loc);
    #1;
    rst   = r;
    stall = st;
    sel   = sl;
    jmp   = loc;
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 20'h00100 + 20'(i);
    rom[5] = 20'hC0040;
    rst = 1'b1; stall = 1'b0; sel = 1'b0; jmp = 8'h00;

    // Reset state
    tick(1'b1, 1'b0, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 1'b0, 8'h00);
    chk("rst_valid", {31'd0, ins_valid}, 32'd0);
    chk("rst_en",    {31'd0, imem_en},   32'd1);
    chk("rst_cur",   {24'd0, cur_addr},  32'h00);
    chk("rst_ins",   {12'd0, ins},       32'h00000);

    // Release and sequential fetch
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    chk("boot_pc",    {24'd0, ins_pc},   32'h00);
    chk("boot_ins",   {12'd0, ins},      32'h00100);
    chk("boot_valid", {31'd0, ins_valid}, 32'd1);
    chk("boot_cur",   {24'd0, cur_addr}, 32'h01);
    repeat (5) tick(1'b0, 1'b0, 1'b0, 8'h00);
    chk("seq_pc5",  {24'd0, ins_pc}, 32'h05);
    chk("seq_ins5", {12'd0, ins},    32'hC0040);

    // Jump to 40: one bubble, then the target
    tick(1'b0, 1'b0, 1'b1, 8'h40);
    chk("jmp_bubble", {31'd0, ins_valid}, 32'd0);
    chk("jmp_cur",    {24'd0, cur_addr},  32'h40);
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    chk("jmp_pc",  {24'd0, ins_pc}, 32'h40);
    chk("jmp_ins", {12'd0, ins},    32'h00140);

    // Stall 3 cycles at ins_pc 10
    tick(1'b0, 1'b0, 1'b1, 8'h0E);
    repeat (3) tick(1'b0, 1'b0, 1'b0, 8'h00);
    chk("pre_stall_pc", {24'd0, ins_pc}, 32'h10);
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 1'b1, 1'b0, 8'h00);
      chk("stall_pc",  {24'd0, ins_pc},   32'h10);
      chk("stall_ins", {12'd0, ins},      32'h00110);
      chk("stall_en",  {31'd0, imem_en},  32'd0);
      chk("stall_vld", {31'd0, ins_valid}, 32'd1);
    end
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    chk("post_stall_pc", {24'd0, ins_pc}, 32'h11);

    // Redirect to F0 with stall while in REFILL
    tick(1'b0, 1'b0, 1'b1, 8'h20);
    tick(1'b0, 1'b1, 1'b1, 8'hF0);
    chk("irq_addr", {24'd0, imem_addr}, 32'hF0);
    chk("irq_cur",  {24'd0, cur_addr},  32'hF0);
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    chk("irq_pc",  {24'd0, ins_pc}, 32'hF0);
    chk("irq_ins", {12'd0, ins},    32'h001F0);

    // Wrap from FE
    tick(1'b0, 1'b0, 1'b1, 8'hFE);
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    chk("wrap_pcFE",  {24'd0, ins_pc},   32'hFE);
    chk("wrap_curFF", {24'd0, cur_addr}, 32'hFF);
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    chk("wrap_pcFF",  {24'd0, ins_pc},   32'hFF);
    chk("wrap_cur00", {24'd0, cur_addr}, 32'h00);
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    chk("wrap_pc00",  {24'd0, ins_pc},   32'h00);
    chk("wrap_cur01", {24'd0, cur_addr}, 32'h01);

    // Reset pulse while in REFILL after jump to 80
    tick(1'b0, 1'b0, 1'b1, 8'h80);
    chk("refill80_addr", {24'd0, imem_addr}, 32'h80);
    #1; rst = 1'b1; sel = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, ins_valid}, 32'd0);
    chk("mid_rst_addr",  {24'd0, imem_addr}, 32'h00);
    chk("mid_rst_cur",   {24'd0, cur_addr},  32'h00);
    tick(1'b1, 1'b0, 1'b0, 8'h00);
    // Redirect request ignored in BOOT
    tick(1'b0, 1'b0, 1'b1, 8'h55);
    chk("boot_ign_pc",  {24'd0, ins_pc},    32'h00);
    chk("boot_ign_vld", {31'd0, ins_valid}, 32'd1);
    chk("boot_ign_ins", {12'd0, ins},       32'h00100);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic       r_r;
      logic       r_st;
      logic       r_sl;
      logic [7:0] r_loc;
      r_r   = ($urandom_range(0, 99) < 2);
      r_st  = ($urandom_range(0, 3) == 0);
      r_sl  = ($urandom_range(0, 6) == 0);
      case ($urandom_range(0, 7))
        0:       r_loc = 8'hFE;
        1:       r_loc = 8'hF0;
        2:       r_loc = 8'hFF;
        default: r_loc = 8'($urandom);
      endcase
      tick(r_r, r_st, r_sl, r_loc);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
